internal_ram_axi_bridge: RTL and testbench
==========================================

# internal_ram_axi_bridge

AXI4 slave front-end for the 16 KB on-chip RAM macro (`Ram_1wrs`: 4096×32, 1-cycle read latency, byte mask, writes to the lower 8 KB ROM half silently dropped inside the RAM). It accepts shared read/write address-channel bursts from the SoC interconnect, sequences per-beat RAM accesses, and returns B/R responses with `r_ready` back-pressure absorbed by a 2-entry read buffer. It sits directly upstream of `Ram_1wrs` and drives its port.

## Interface
- `ADDR_BITS`, 14: byte-address width; word address is `addr[ADDR_BITS-1:2]` (12 bits).
- `clk` in 1: sole clock; all logic on rising edge.
- `reset` in 1: asynchronous, active-high.
- `axi_arw_valid` in 1, `axi_arw_ready` out 1: address handshake.
- `axi_arw_payload_addr` in ADDR_BITS: byte address; bits [1:0] ignored.
- `axi_arw_payload_id` in 1: transaction ID.
- `axi_arw_payload_len` in 8: beats − 1.
- `axi_arw_payload_size` in 3: ignored; every beat is 32 bits.
- `axi_arw_payload_burst` in 2: 00 FIXED, 01 INCR, 10 WRAP; 11 treated as INCR.
- `axi_arw_payload_write` in 1: 1 = write, 0 = read.
- `axi_w_valid` in 1, `axi_w_ready` out 1, `axi_w_payload_data` in 32, `axi_w_payload_strb` in 4, `axi_w_payload_last` in 1 (ignored).
- `axi_b_valid` out 1, `axi_b_ready` in 1, `axi_b_payload_id` out 1.
- `axi_r_valid` out 1, `axi_r_ready` in 1, `axi_r_payload_data` out 32, `axi_r_payload_id` out 1, `axi_r_payload_last` out 1.
- `ram_en` out 1, `ram_wr` out 1, `ram_addr` out 12, `ram_mask` out 4, `ram_wrData` out 32: RAM port.
- `ram_rdData` in 32: RAM read data, valid the cycle after a `ram_en` read.

## Operation
- FSM: IDLE, WRITE, WRITE_RESP, READ. Exactly one transaction in flight.
- IDLE: `axi_arw_ready`=1 (0 while `reset` asserted). On handshake, latch word address, len, burst, id; clear beat counter; go to WRITE or READ.
- Address step after each issued beat: FIXED holds; INCR +1 mod 4096; WRAP `(a & ~len) | ((a+1) & len)` on the low 8 bits, legal for len ∈ {1,3,7,15}.
- WRITE: `axi_w_ready`=1. Each W handshake drives, in the same cycle, `ram_en`=1, `ram_wr`=1, `ram_addr`=current word, `ram_mask`=strb, `ram_wrData`=data. After len+1 beats → WRITE_RESP. Writes to ROM (`ram_addr[11]`=0) pass unchanged to the RAM, which drops them; bridge responds normally.
- WRITE_RESP: `axi_b_valid`=1, id = latched id; on `axi_b_ready` → IDLE.
- READ: issue read beat (`ram_en`=1, `ram_wr`=0) when issued-count ≤ len and (buffer occupancy + in-flight − R pop this cycle) < 2. Data returned next cycle is pushed into a 2-entry FIFO. R channel presents FIFO head; `r_last`=1 on beat len; id = latched id. After last beat accepted → IDLE.
- `ram_en`=0 whenever no beat is issued; `ram_mask`, `ram_wrData` are don't-care on reads.

## Timing
- Reset values: all valids 0, `axi_w_ready` 0, `axi_arw_ready` 0 during reset, `ram_en`/`ram_wr` 0, FIFO empty, state IDLE. Reset mid-burst abandons it; no partial response.
- Write: handshake at edge E0; `axi_w_ready` high from cycle 1; 1 beat/cycle with `w_valid` held; `b_valid` first cycle after last W beat.
- Read: handshake at E0; beat 0 `ram_en` in cycle 1; `ram_rdData` valid cycle 2; captured at E2; `r_valid` from cycle 3. With `r_ready`=1, 1 beat/cycle; len=0 read → `r_valid` cycle 3 with `r_last`=1.
- `r_ready` low: FIFO fills to 2, issue stalls, no data lost; resumes the cycle after a pop.
- `axi_arw_ready` returns high the cycle after final B or R handshake.
- Write-then-read to same word: read data reflects the write (WRITE_RESP guarantees ≥1 cycle gap).

## Test plan
- INCR write len=3 at 0x2000, strb=F, data 1..4; then INCR read len=3 -> R beats 1,2,3,4, last on beat 4, id echoed, `b_valid` 1 cycle after 4th W beat.
- WRAP read len=3 at 0x200C after filling 0x2000–0x200C with A,B,C,D -> D,A,B,C.
- Write 0xDEADBEEF to 0x0004 (ROM) -> B response issued; read back returns original ROM contents.
- Read len=7 with `r_ready` toggling 1/0 every cycle -> all 8 beats in order, `ram_en` never issues with FIFO + in-flight ≥ 2.
- Partial strobe write strb=0101 data 0x11223344 over 0xFFFFFFFF at 0x3000 -> byte lanes 0,2 updated.
- Assert `reset` mid read burst -> all valids 0 asynchronously; after release `axi_arw_ready`=1 and a new read completes correctly.

Source files
------------

// File: rtl/internal_ram_axi_bridge.sv
// AXI4 slave front-end for the 4096x32 on-chip RAM: one burst in flight,
// per-beat RAM sequencing, and a 2-entry read buffer to absorb r_ready stalls.
module internal_ram_axi_bridge #(
  parameter int ADDR_BITS = 14
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 axi_arw_valid,
  output logic                 axi_arw_ready,
  input  logic [ADDR_BITS-1:0] axi_arw_payload_addr,
  input  logic                 axi_arw_payload_id,
  input  logic [7:0]           axi_arw_payload_len,
  input  logic [2:0]           axi_arw_payload_size,
  input  logic [1:0]           axi_arw_payload_burst,
  input  logic                 axi_arw_payload_write,
  input  logic                 axi_w_valid,
  output logic                 axi_w_ready,
  input  logic [31:0]          axi_w_payload_data,
  input  logic [3:0]           axi_w_payload_strb,
  input  logic                 axi_w_payload_last,
  output logic                 axi_b_valid,
  input  logic                 axi_b_ready,
  output logic                 axi_b_payload_id,
  output logic                 axi_r_valid,
  input  logic                 axi_r_ready,
  output logic [31:0]          axi_r_payload_data,
  output logic                 axi_r_payload_id,
  output logic                 axi_r_payload_last,
  output logic                 ram_en,
  output logic                 ram_wr,
  output logic [11:0]          ram_addr,
  output logic [3:0]           ram_mask,
  output logic [31:0]          ram_wrData,
  input  logic [31:0]          ram_rdData
);

  typedef enum logic [1:0] {IDLE, WRITE, WRITE_RESP, READ} state_t;

  state_t            state, state_nxt;
  logic [11:0]       addr_q;
  logic [7:0]        len_q;
  logic [1:0]        burst_q;
  logic              id_q;
  logic [8:0]        beat_q;
  logic              in_flight_q, in_flight_last_q;
  logic [1:0][31:0]  fifo_data;
  logic [1:0]        fifo_last;
  logic              rd_ptr, wr_ptr;
  logic [1:0]        count_q;

  logic              arw_fire, w_fire, r_fire, issue, push, last_beat;
  logic [2:0]        occupancy;
  logic              unused_bits;

  assign unused_bits = ^{axi_arw_payload_size, axi_w_payload_last, axi_arw_payload_addr[1:0]};

  function automatic logic [11:0] step_addr(input logic [11:0] a, input logic [1:0] b,
                                            input logic [7:0] l);
    logic [7:0] inc;
    inc = a[7:0] + 8'd1;
    case (b)
      2'b00:   step_addr = a;
      2'b10:   step_addr = {a[11:8], (a[7:0] & ~l) | (inc & l)};
      default: step_addr = a + 12'd1;
    endcase
  endfunction

  assign arw_fire  = axi_arw_valid && axi_arw_ready;
  assign w_fire    = (state == WRITE) && axi_w_valid;
  assign axi_r_valid = (count_q != 2'd0);
  assign r_fire    = axi_r_valid && axi_r_ready;
  assign push      = in_flight_q;
  assign last_beat = (beat_q == {1'b0, len_q});
  // Slots already committed (buffered + data arriving) after this cycle's pop.
  assign occupancy = {1'b0, count_q} + {2'b0, in_flight_q} - {2'b0, r_fire};

  assign axi_b_payload_id   = id_q;
  assign axi_r_payload_id   = id_q;
  assign axi_r_payload_data = fifo_data[rd_ptr];
  assign axi_r_payload_last = fifo_last[rd_ptr];
  assign ram_addr           = addr_q;

  always_comb begin
    state_nxt     = state;
    axi_arw_ready = 1'b0;
    axi_w_ready   = 1'b0;
    axi_b_valid   = 1'b0;
    issue         = 1'b0;
    ram_en        = 1'b0;
    ram_wr        = 1'b0;
    ram_mask      = axi_w_payload_strb;
    ram_wrData    = axi_w_payload_data;
    case (state)
      IDLE: begin
        axi_arw_ready = !reset;
        if (arw_fire) state_nxt = axi_arw_payload_write ? WRITE : READ;
      end
      WRITE: begin
        axi_w_ready = 1'b1;
        if (axi_w_valid) begin
          ram_en = 1'b1;
          ram_wr = 1'b1;
          if (last_beat) state_nxt = WRITE_RESP;
        end
      end
      WRITE_RESP: begin
        axi_b_valid = 1'b1;
        if (axi_b_ready) state_nxt = IDLE;
      end
      READ: begin
        if ((beat_q <= {1'b0, len_q}) && (occupancy < 3'd2)) begin
          issue  = 1'b1;
          ram_en = 1'b1;
        end
        if (r_fire && axi_r_payload_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= IDLE;
      addr_q           <= '0;
      len_q            <= '0;
      burst_q          <= '0;
      id_q             <= 1'b0;
      beat_q           <= '0;
      in_flight_q      <= 1'b0;
      in_flight_last_q <= 1'b0;
      fifo_data        <= '0;
      fifo_last        <= '0;
      rd_ptr           <= 1'b0;
      wr_ptr           <= 1'b0;
      count_q          <= '0;
    end else begin
      state <= state_nxt;
      if (arw_fire) begin
        addr_q  <= axi_arw_payload_addr[ADDR_BITS-1:2];
        len_q   <= axi_arw_payload_len;
        burst_q <= axi_arw_payload_burst;
        id_q    <= axi_arw_payload_id;
        beat_q  <= '0;
      end else if (w_fire || issue) begin
        addr_q <= step_addr(addr_q, burst_q, len_q);
        beat_q <= beat_q + 9'd1;
      end
      in_flight_q      <= issue;
      in_flight_last_q <= last_beat;
      if (push) begin
        fifo_data[wr_ptr] <= ram_rdData;
        fifo_last[wr_ptr] <= in_flight_last_q;
        wr_ptr            <= ~wr_ptr;
      end
      if (r_fire) rd_ptr <= ~rd_ptr;
      count_q <= count_q + {1'b0, push} - {1'b0, r_fire};
    end
  end

endmodule

// File: tb/tb_internal_ram_axi_bridge.sv
// Directed bench for internal_ram_axi_bridge with a behavioural 4096x32 RAM
// (1-cycle read, byte mask, lower half read-only) attached to its RAM port.
module tb_internal_ram_axi_bridge;
  localparam int ADDR_BITS = 14;

  logic        clk = 1'b0;
  logic        reset;
  logic        axi_arw_valid, axi_arw_ready;
  logic [13:0] axi_arw_payload_addr;
  logic        axi_arw_payload_id;
  logic [7:0]  axi_arw_payload_len;
  logic [2:0]  axi_arw_payload_size;
  logic [1:0]  axi_arw_payload_burst;
  logic        axi_arw_payload_write;
  logic        axi_w_valid, axi_w_ready;
  logic [31:0] axi_w_payload_data;
  logic [3:0]  axi_w_payload_strb;
  logic        axi_w_payload_last;
  logic        axi_b_valid, axi_b_ready, axi_b_payload_id;
  logic        axi_r_valid, axi_r_ready;
  logic [31:0] axi_r_payload_data;
  logic        axi_r_payload_id, axi_r_payload_last;
  logic        ram_en, ram_wr;
  logic [11:0] ram_addr;
  logic [3:0]  ram_mask;
  logic [31:0] ram_wrData, ram_rdData;

  internal_ram_axi_bridge #(.ADDR_BITS(ADDR_BITS)) dut (
    .clk(clk), .reset(reset),
    .axi_arw_valid(axi_arw_valid), .axi_arw_ready(axi_arw_ready),
    .axi_arw_payload_addr(axi_arw_payload_addr), .axi_arw_payload_id(axi_arw_payload_id),
    .axi_arw_payload_len(axi_arw_payload_len), .axi_arw_payload_size(axi_arw_payload_size),
    .axi_arw_payload_burst(axi_arw_payload_burst), .axi_arw_payload_write(axi_arw_payload_write),
    .axi_w_valid(axi_w_valid), .axi_w_ready(axi_w_ready),
    .axi_w_payload_data(axi_w_payload_data), .axi_w_payload_strb(axi_w_payload_strb),
    .axi_w_payload_last(axi_w_payload_last),
    .axi_b_valid(axi_b_valid), .axi_b_ready(axi_b_ready), .axi_b_payload_id(axi_b_payload_id),
    .axi_r_valid(axi_r_valid), .axi_r_ready(axi_r_ready),
    .axi_r_payload_data(axi_r_payload_data), .axi_r_payload_id(axi_r_payload_id),
    .axi_r_payload_last(axi_r_payload_last),
    .ram_en(ram_en), .ram_wr(ram_wr), .ram_addr(ram_addr), .ram_mask(ram_mask),
    .ram_wrData(ram_wrData), .ram_rdData(ram_rdData)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [4096];
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_wr) begin
        if (ram_addr[11])
          for (int b = 0; b < 4; b++)
            if (ram_mask[b]) mem[ram_addr][8*b +: 8] = ram_wrData[8*b +: 8];
      end else begin
        ram_rdData <= mem[ram_addr];
      end
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  logic [31:0] wbuf  [16];
  logic [31:0] rbuf  [16];
  logic        rlast [16];
  logic        rid   [16];

  task automatic do_arw(input logic [13:0] a, input logic [7:0] l, input logic [1:0] b,
                        input logic i, input logic wr);
    int n = 0;
    axi_arw_valid = 1'b1;
    axi_arw_payload_addr = a;
    axi_arw_payload_len = l;
    axi_arw_payload_burst = b;
    axi_arw_payload_id = i;
    axi_arw_payload_write = wr;
    axi_arw_payload_size = 3'd2;
    while (!axi_arw_ready && n < 50) begin @(negedge clk); n++; end
    chk("arw_handshake", (n < 50) ? 32'd1 : 32'd0, 32'd1);
    @(negedge clk);
    axi_arw_valid = 1'b0;
  endtask

  task automatic do_write(input logic [13:0] a, input logic [7:0] l, input logic [1:0] b,
                          input logic i, input logic [3:0] s);
    int n;
    do_arw(a, l, b, i, 1'b1);
    chk("w_ready_cycle1", axi_w_ready, 1);
    for (int k = 0; k <= int'(l); k++) begin
      axi_w_valid = 1'b1;
      axi_w_payload_data = wbuf[k];
      axi_w_payload_strb = s;
      axi_w_payload_last = (k == int'(l));
      n = 0;
      while (!axi_w_ready && n < 50) begin @(negedge clk); n++; end
      @(negedge clk);
    end
    axi_w_valid = 1'b0;
    axi_w_payload_last = 1'b0;
    chk("b_valid_after_last_w", axi_b_valid, 1);
    chk("b_id", axi_b_payload_id, i);
    axi_b_ready = 1'b1;
    @(negedge clk);
    axi_b_ready = 1'b0;
    chk("arw_ready_after_b", axi_arw_ready, 1);
  endtask

  task automatic do_read(input logic [13:0] a, input logic [7:0] l, input logic [1:0] b,
                         input logic i, input bit toggle,
                         output int first_rv, output int first_en, output int viol);
    int got = 0, cyc = 1, iss = 0, pops = 0;
    logic pop;
    first_rv = 0; first_en = 0; viol = 0;
    do_arw(a, l, b, i, 1'b0);
    while (got <= int'(l) && cyc < 300) begin
      axi_r_ready = toggle ? cyc[0] : 1'b1;
      #1;
      pop = axi_r_valid && axi_r_ready;
      if (axi_r_valid && first_rv == 0) first_rv = cyc;
      if (ram_en && !ram_wr) begin
        if (first_en == 0) first_en = cyc;
        if (iss - pops - int'(pop) >= 2) viol++;
        iss++;
      end
      if (pop) begin
        rbuf[got] = axi_r_payload_data;
        rlast[got] = axi_r_payload_last;
        rid[got] = axi_r_payload_id;
        got++;
        pops++;
      end
      @(negedge clk);
      cyc++;
    end
    axi_r_ready = 1'b0;
    chk("r_beats_received", got, int'(l) + 1);
    chk("ram_reads_issued", iss, int'(l) + 1);
    chk("arw_ready_after_r", axi_arw_ready, 1);
    chk("r_valid_after_burst", axi_r_valid, 0);
  endtask

  task automatic chk_beats(input string tag, input int n, input logic i);
    for (int k = 0; k < n; k++) begin
      chk($sformatf("%s_last%0d", tag, k), rlast[k], (k == n - 1) ? 1'b1 : 1'b0);
      chk($sformatf("%s_id%0d", tag, k), rid[k], i);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int frv, fen, vio;
    for (int w = 0; w < 4096; w++) mem[w] = 32'hC0DE0000 | w;
    reset = 1'b1;
    axi_arw_valid = 0; axi_arw_payload_addr = 0; axi_arw_payload_id = 0;
    axi_arw_payload_len = 0; axi_arw_payload_size = 0; axi_arw_payload_burst = 0;
    axi_arw_payload_write = 0; axi_w_valid = 0; axi_w_payload_data = 0;
    axi_w_payload_strb = 0; axi_w_payload_last = 0; axi_b_ready = 0; axi_r_ready = 0;
    #12;
    chk("rst_arw_ready", axi_arw_ready, 0);
    chk("rst_w_ready", axi_w_ready, 0);
    chk("rst_b_valid", axi_b_valid, 0);
    chk("rst_r_valid", axi_r_valid, 0);
    chk("rst_ram_en", ram_en, 0);
    @(negedge clk); reset = 1'b0;
    @(negedge clk);
    chk("idle_arw_ready", axi_arw_ready, 1);

    // INCR write 1..4 then read back
    for (int k = 0; k < 4; k++) wbuf[k] = k + 1;
    do_write(14'h2000, 8'd3, 2'b01, 1'b1, 4'hF);
    do_read(14'h2000, 8'd3, 2'b01, 1'b1, 1'b0, frv, fen, vio);
    chk("incr_first_ram_en", fen, 1);
    chk("incr_first_r_valid", frv, 3);
    for (int k = 0; k < 4; k++) chk($sformatf("incr_d%0d", k), rbuf[k], k + 1);
    chk_beats("incr", 4, 1'b1);

    // WRAP read starting at last word of a 4-word block
    wbuf[0] = 32'hA; wbuf[1] = 32'hB; wbuf[2] = 32'hC; wbuf[3] = 32'hD;
    do_write(14'h2000, 8'd3, 2'b01, 1'b0, 4'hF);
    do_read(14'h200C, 8'd3, 2'b10, 1'b0, 1'b0, frv, fen, vio);
    chk("wrap_d0", rbuf[0], 32'hD);
    chk("wrap_d1", rbuf[1], 32'hA);
    chk("wrap_d2", rbuf[2], 32'hB);
    chk("wrap_d3", rbuf[3], 32'hC);
    chk_beats("wrap", 4, 1'b0);

    // FIXED read repeats one word
    do_read(14'h2004, 8'd2, 2'b00, 1'b0, 1'b0, frv, fen, vio);
    for (int k = 0; k < 3; k++) chk($sformatf("fixed_d%0d", k), rbuf[k], 32'hB);

    // ROM write is acknowledged but has no effect
    wbuf[0] = 32'hDEADBEEF;
    do_write(14'h0004, 8'd0, 2'b01, 1'b1, 4'hF);
    do_read(14'h0004, 8'd0, 2'b01, 1'b1, 1'b0, frv, fen, vio);
    chk("rom_data", rbuf[0], 32'hC0DE0001);
    chk("rom_len0_last", rlast[0], 1);
    chk("rom_len0_first_r_valid", frv, 3);

    // len=7 read with r_ready toggling
    do_read(14'h2000, 8'd7, 2'b01, 1'b0, 1'b1, frv, fen, vio);
    chk("bp_d0", rbuf[0], 32'hA);
    chk("bp_d1", rbuf[1], 32'hB);
    chk("bp_d2", rbuf[2], 32'hC);
    chk("bp_d3", rbuf[3], 32'hD);
    for (int k = 4; k < 8; k++) chk($sformatf("bp_d%0d", k), rbuf[k], 32'hC0DE0800 | k);
    chk_beats("bp", 8, 1'b0);
    chk("bp_overissue", vio, 0);

    // partial strobe write
    wbuf[0] = 32'hFFFFFFFF;
    do_write(14'h3000, 8'd0, 2'b01, 1'b0, 4'hF);
    wbuf[0] = 32'h11223344;
    do_write(14'h3000, 8'd0, 2'b01, 1'b0, 4'b0101);
    do_read(14'h3000, 8'd0, 2'b01, 1'b0, 1'b0, frv, fen, vio);
    chk("strb_data", rbuf[0], 32'hFF22FF44);

    // reset in the middle of a stalled read burst
    do_arw(14'h2000, 8'd7, 2'b01, 1'b1, 1'b0);
    axi_r_ready = 1'b0;
    repeat (4) @(negedge clk);
    chk("mid_r_valid_before_rst", axi_r_valid, 1);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_r_valid", axi_r_valid, 0);
    chk("mid_rst_ram_en", ram_en, 0);
    chk("mid_rst_arw_ready", axi_arw_ready, 0);
    chk("mid_rst_b_valid", axi_b_valid, 0);
    @(negedge clk); reset = 1'b0;
    @(negedge clk);
    chk("post_rst_arw_ready", axi_arw_ready, 1);
    do_read(14'h2000, 8'd1, 2'b01, 1'b1, 1'b0, frv, fen, vio);
    chk("post_rst_d0", rbuf[0], 32'hA);
    chk("post_rst_d1", rbuf[1], 32'hB);
    chk_beats("post_rst", 2, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
